// File: rtl/jtag_uart_ctrl.sv
// Avalon-MM master that drives the JTAG UART slave: buffers TX bytes, tracks the slave's
// write space, and fetches RX bytes on poll timeout or interrupt.
module jtag_uart_ctrl #(
    parameter int TX_DEPTH    = 8,
    parameter int POLL_CYCLES = 1024
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic [7:0]  tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic        busy,
    output logic        av_chipselect,
    output logic        av_address,
    output logic        av_read_n,
    output logic        av_write_n,
    output logic [31:0] av_writedata,
    input  logic [31:0] av_readdata,
    input  logic        av_waitrequest,
    input  logic        av_irq
);

    localparam int PW = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
    localparam int LW = PW + 1;
    localparam int TW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
    localparam logic [TW-1:0] RELOAD     = TW'(POLL_CYCLES - 1);
    localparam logic [LW-1:0] FULL_LEVEL = LW'(TX_DEPTH);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_RD_CTRL,
        S_WR_DATA,
        S_RD_DATA
    } state_t;

    state_t         state_q, state_d;
    logic           cs_q, cs_d;
    logic           addr_q, addr_d;
    logic           read_n_q, read_n_d;
    logic           write_n_q, write_n_d;
    logic [31:0]    wdata_q, wdata_d;
    logic [7:0]     rx_data_q, rx_data_d;
    logic           rx_valid_q, rx_valid_d;
    logic [15:0]    wspace_q, wspace_d;
    logic           rx_pend_q, rx_pend_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic           last_rx_q, last_rx_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]  level_q, level_d;

    logic [7:0]     fifo_mem [TX_DEPTH];
    logic           fifo_full;
    logic           fifo_empty;
    logic           push;
    logic           pop;
    logic           done;
    logic           txw;
    logic           txc;
    logic           rxr;
    logic           grant_rx;
    logic           unused_readdata;

    assign fifo_full  = (level_q == FULL_LEVEL);
    assign fifo_empty = (level_q == '0);
    assign tx_ready   = (state_q != S_INIT) && !fifo_full;
    assign push       = tx_valid && tx_ready;
    assign done       = cs_q && !av_waitrequest;

    assign txw      = !fifo_empty && (wspace_q != 16'h0);
    assign txc      = !fifo_empty && (wspace_q == 16'h0) && (timer_q == '0);
    assign rxr      = rx_pend_q && !rx_valid_q;
    // On a tie the side that did not win last time takes the bus.
    assign grant_rx = rxr && (!(txw || txc) || !last_rx_q);

    assign unused_readdata = ^av_readdata[14:8];

    always_ff @(posedge clk_clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= tx_data;
        end
    end

    always_comb begin
        state_d    = state_q;
        cs_d       = cs_q;
        addr_d     = addr_q;
        read_n_d   = read_n_q;
        write_n_d  = write_n_q;
        wdata_d    = wdata_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        wspace_d   = wspace_q;
        rx_pend_d  = rx_pend_q;
        last_rx_d  = last_rx_q;
        pop        = 1'b0;
        timer_d    = (timer_q != '0) ? timer_q - TW'(1) : timer_q;

        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end

        case (state_q)
            S_INIT: begin
                if (!cs_q) begin
                    cs_d      = 1'b1;
                    addr_d    = 1'b1;
                    write_n_d = 1'b0;
                    wdata_d   = 32'h1;
                end else if (done) begin
                    cs_d      = 1'b0;
                    write_n_d = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            S_IDLE: begin
                if (grant_rx) begin
                    state_d   = S_RD_DATA;
                    cs_d      = 1'b1;
                    addr_d    = 1'b0;
                    read_n_d  = 1'b0;
                    last_rx_d = 1'b1;
                end else if (txw) begin
                    state_d   = S_WR_DATA;
                    cs_d      = 1'b1;
                    addr_d    = 1'b0;
                    write_n_d = 1'b0;
                    wdata_d   = {24'h0, fifo_mem[rd_ptr_q]};
                    last_rx_d = 1'b0;
                end else if (txc) begin
                    state_d   = S_RD_CTRL;
                    cs_d      = 1'b1;
                    addr_d    = 1'b1;
                    read_n_d  = 1'b0;
                    last_rx_d = 1'b0;
                end
            end
            S_RD_CTRL: begin
                if (done) begin
                    cs_d     = 1'b0;
                    read_n_d = 1'b1;
                    state_d  = S_IDLE;
                    wspace_d = av_readdata[31:16];
                    if (av_readdata[31:16] == 16'h0) begin
                        timer_d = RELOAD;
                    end
                end
            end
            S_WR_DATA: begin
                if (done) begin
                    cs_d      = 1'b0;
                    write_n_d = 1'b1;
                    state_d   = S_IDLE;
                    pop       = 1'b1;
                    wspace_d  = wspace_q - 16'h1;
                end
            end
            S_RD_DATA: begin
                if (done) begin
                    cs_d     = 1'b0;
                    read_n_d = 1'b1;
                    state_d  = S_IDLE;
                    if (av_readdata[15]) begin
                        rx_data_d  = av_readdata[7:0];
                        rx_valid_d = 1'b1;
                    end
                    rx_pend_d = (av_readdata[31:16] != 16'h0);
                    if (av_readdata[31:16] == 16'h0) begin
                        timer_d = RELOAD;
                    end
                end
            end
            default: begin
                state_d = S_INIT;
            end
        endcase

        // A level interrupt keeps the RX side pending even if the last read drained it.
        if (((timer_q == '0) && !rx_pend_q) || av_irq) begin
            rx_pend_d = 1'b1;
            timer_d   = RELOAD;
        end

        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        level_d  = level_q + LW'(push) - LW'(pop);
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            state_q    <= S_INIT;
            cs_q       <= 1'b0;
            addr_q     <= 1'b0;
            read_n_q   <= 1'b1;
            write_n_q  <= 1'b1;
            wdata_q    <= 32'h0;
            rx_data_q  <= 8'h0;
            rx_valid_q <= 1'b0;
            wspace_q   <= 16'h0;
            rx_pend_q  <= 1'b0;
            timer_q    <= RELOAD;
            last_rx_q  <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
        end else begin
            state_q    <= state_d;
            cs_q       <= cs_d;
            addr_q     <= addr_d;
            read_n_q   <= read_n_d;
            write_n_q  <= write_n_d;
            wdata_q    <= wdata_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            wspace_q   <= wspace_d;
            rx_pend_q  <= rx_pend_d;
            timer_q    <= timer_d;
            last_rx_q  <= last_rx_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
        end
    end

    assign rx_data       = rx_data_q;
    assign rx_valid      = rx_valid_q;
    assign busy          = cs_q;
    assign av_chipselect = cs_q;
    assign av_address    = addr_q;
    assign av_read_n     = read_n_q;
    assign av_write_n    = write_n_q;
    assign av_writedata  = wdata_q;

endmodule
